// File: rtl/alpha_filter_reader_pkg.sv
// alpha_filter_reader shared definitions: SDRAM bus widths,
// IQ slice layout within a 256-bit word, reader FSM states.
package alpha_filter_reader_pkg;

  localparam int SDRAM_ADDR_W = 27;
  localparam int SDRAM_DATA_W = 256;
  localparam int SDRAM_BE_W   = 32;

  localparam int IQ_W             = 32;
  localparam int SAMPLES_PER_WORD = 8;
  localparam int SAMP_IDX_W       = 3;

  // I in the low half of each 32-bit slice, Q in the high half.
  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } iqSample_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
  } readState_t;

  function automatic iqSample_t wordSample(
    input logic [SDRAM_DATA_W-1:0] w,
    input logic [SAMP_IDX_W-1:0]   k
  );
    return iqSample_t'(w[IQ_W*k +: IQ_W]);
  endfunction

endpackage

// File: rtl/alpha_filter_reader_fifo.sv
// Show-ahead FIFO for returned SDRAM words.
// Ports: ipClk/ipReset, ipFlush, ipPush/ipData, ipPop, opData (head), opEmpty, opCount.
module alpha_filter_reader_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             ipFlush,
  input  logic             ipPush,
  input  logic [WIDTH-1:0] ipData,
  input  logic             ipPop,
  output logic [WIDTH-1:0] opData,
  output logic             opEmpty,
  output logic [CW-1:0]    opCount
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign opEmpty = (opCount == '0);
  assign doPop   = ipPop && !opEmpty;
  // A push into a full FIFO is only taken if a pop frees the slot.
  assign doPush  = ipPush
                && ((opCount != CW'(DEPTH)) || doPop);
  assign opData  = mem[rdPtr];

  always_ff @(posedge ipClk) begin
    if (doPush && !ipFlush) begin
      mem[wrPtr] <= ipData;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      opCount <= '0;
    end else if (ipFlush) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      opCount <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= bump(wrPtr);
      end
      if (doPop) begin
        rdPtr <= bump(rdPtr);
      end
      unique case (1'b1)
        doPush && !doPop: opCount <= opCount + 1'b1;
        doPop && !doPush: opCount <= opCount - 1'b1;
        default:          opCount <= opCount;
      endcase
    end
  end

endmodule

// File: rtl/alpha_filter_reader.sv
// Avalon-MM burst reader replaying the alpha-filter SDRAM ring as IQ samples.
// Ports: ipClk/ipReset, ipEnable, ipWrOffset/opRdOffset/opOverrun,
//   opSDRAM_* / ipSDRAM_* burst read master, opOutput_I/Q/Valid + ipOutput_Ready.
module alpha_filter_reader
  import alpha_filter_reader_pkg::*;
#(
  parameter logic [26:0] BASE_ADDR  = '0,
  parameter int          BUF_WORDS  = 1048576,
  parameter int          BURST_LEN  = 8,
  parameter int          FIFO_DEPTH = 32
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  logic                    ipEnable,
  input  logic [SDRAM_ADDR_W-1:0] ipWrOffset,
  output logic [SDRAM_ADDR_W-1:0] opRdOffset,
  output logic                    opOverrun,
  input  logic                    ipSDRAM_WaitRequest,
  output logic [SDRAM_ADDR_W-1:0] opSDRAM_Address,
  output logic [SDRAM_BE_W-1:0]   opSDRAM_ByteEnable,
  output logic [7:0]              opSDRAM_BurstCount,
  output logic                    opSDRAM_Read,
  input  logic [SDRAM_DATA_W-1:0] ipSDRAM_ReadData,
  input  logic                    ipSDRAM_ReadValid,
  output logic [15:0]             opOutput_I,
  output logic [15:0]             opOutput_Q,
  output logic                    opOutput_Valid,
  input  logic                    ipOutput_Ready
);

  localparam int AW = SDRAM_ADDR_W;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] RING_MASK = AW'(BUF_WORDS - 1);
  localparam logic [AW-1:0] BURST_W   = AW'(BURST_LEN);
  localparam logic [AW-1:0] OVR_LIMIT = AW'(BUF_WORDS - 2 * BURST_LEN);

  readState_t state;

  logic [AW-1:0] rdOff;
  logic [AW-1:0] avail;
  logic [7:0]    beatCnt;
  logic [7:0]    owed;
  logic [15:0]   pendWords;
  logic          enPrev;
  logic          enRise;
  logic          runOk;
  logic          flush;
  logic          availOk;
  logic          roomOk;
  logic          discard;
  logic          lastBeat;

  logic                    push;
  logic                    pop;
  logic [SDRAM_DATA_W-1:0] fifoData;
  logic                    fifoEmpty;
  logic [CW-1:0]           fifoCount;

  logic [SAMP_IDX_W-1:0] sampIdx;
  logic                  canLoad;
  logic                  lastSample;
  iqSample_t             curSample;

  assign opSDRAM_ByteEnable = '1;
  assign opSDRAM_BurstCount = 8'(BURST_LEN);
  assign opRdOffset         = rdOff;

  assign enRise = ipEnable && !enPrev;
  // The rise cycle still sees the old rdOff, so requests wait one cycle.
  assign runOk  = ipEnable && enPrev;
  assign flush  = !ipEnable || enRise;

  assign avail   = (ipWrOffset - rdOff) & RING_MASK;
  assign availOk = (avail >= BURST_W);

  always_comb begin
    owed = '0;
    unique case (state)
      REQ:     owed = 8'(BURST_LEN);
      DATA:    owed = 8'(BURST_LEN) - beatCnt;
      default: owed = '0;
    endcase
  end

  assign pendWords = 16'(fifoCount) + 16'(owed);
  assign roomOk    = (pendWords + 16'(BURST_LEN))
                  <= 16'(FIFO_DEPTH);
  assign lastBeat  = (beatCnt == 8'(BURST_LEN - 1));

  assign push = (state == DATA) && ipSDRAM_ReadValid
             && !discard && ipEnable;

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state           <= IDLE;
      rdOff           <= '0;
      opSDRAM_Address <= BASE_ADDR;
      opSDRAM_Read    <= 1'b0;
      opOverrun       <= 1'b0;
      beatCnt         <= '0;
      discard         <= 1'b0;
      enPrev          <= 1'b0;
    end else begin
      enPrev <= ipEnable;
      if (enRise) begin
        rdOff     <= ipWrOffset;
        opOverrun <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (runOk) begin
            if (avail > OVR_LIMIT) begin
              opOverrun <= 1'b1;
            end
            if (availOk && roomOk) begin
              state           <= REQ;
              opSDRAM_Read    <= 1'b1;
              opSDRAM_Address <= BASE_ADDR + rdOff;
            end
          end
        end
        REQ: begin
          // An accepted burst is owed to us even if enable just fell.
          if (!ipSDRAM_WaitRequest) begin
            state        <= DATA;
            opSDRAM_Read <= 1'b0;
            rdOff        <= (rdOff + BURST_W) & RING_MASK;
            beatCnt      <= '0;
            discard      <= !ipEnable;
          end else if (!ipEnable) begin
            state        <= IDLE;
            opSDRAM_Read <= 1'b0;
          end
        end
        DATA: begin
          if (!ipEnable) begin
            discard <= 1'b1;
          end
          if (ipSDRAM_ReadValid) begin
            beatCnt <= beatCnt + 8'd1;
            if (lastBeat) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          opSDRAM_Read <= 1'b0;
        end
      endcase
    end
  end

  alpha_filter_reader_fifo #(
    .WIDTH (SDRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .ipClk   (ipClk),
    .ipReset (ipReset),
    .ipFlush (flush),
    .ipPush  (push),
    .ipData  (ipSDRAM_ReadData),
    .ipPop   (pop),
    .opData  (fifoData),
    .opEmpty (fifoEmpty),
    .opCount (fifoCount)
  );

  // The output register is a one-deep stage fed from the FIFO head;
  // a word is popped as its last sample moves into that stage.
  assign canLoad    = !opOutput_Valid || ipOutput_Ready;
  assign lastSample = (sampIdx == SAMP_IDX_W'(SAMPLES_PER_WORD - 1));
  assign curSample  = wordSample(fifoData, sampIdx);
  assign pop        = !flush && canLoad && !fifoEmpty && lastSample;

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      opOutput_Valid <= 1'b0;
      opOutput_I     <= '0;
      opOutput_Q     <= '0;
      sampIdx        <= '0;
    end else if (flush) begin
      opOutput_Valid <= 1'b0;
      sampIdx        <= '0;
    end else if (canLoad) begin
      if (!fifoEmpty) begin
        opOutput_Valid <= 1'b1;
        opOutput_I     <= curSample.i;
        opOutput_Q     <= curSample.q;
        sampIdx        <= sampIdx + 1'b1;
      end else begin
        opOutput_Valid <= 1'b0;
      end
    end
  end

endmodule
